// File: rtl/bus_mem_responder_if.sv
// Bus bundle between the 8088 datapath (master) and the memory responder (slave).
// Signals:
//   req        request strobe (master -> slave)
//   RD_WR      0 = read, 1 = write (master -> slave)
//   Direction  byte address of the low byte of the word (master -> slave)
//   Data_wr    16-bit write data (master -> slave)
//   Data_rd    16-bit read data, valid while ready = 1 (slave -> master)
//   ready      one-cycle completion pulse (slave -> master)
//   busy       transaction in progress (slave -> master)
//   err        out-of-range flag, valid while ready = 1 (slave -> master)
interface bus_mem_responder_if #(
    parameter int ADDR_W = 20
);
    logic              req;
    logic              RD_WR;
    logic [ADDR_W-1:0] Direction;
    logic [15:0]       Data_wr;
    logic [15:0]       Data_rd;
    logic              ready;
    logic              busy;
    logic              err;

    modport master (
        output req, RD_WR, Direction, Data_wr,
        input  Data_rd, ready, busy, err
    );

    modport slave (
        input  req, RD_WR, Direction, Data_wr,
        output Data_rd, ready, busy, err
    );
endinterface

// File: rtl/bus_mem_responder.sv
// Memory-side responder for the 8088 bus. Serves word reads/writes from a
// byte-addressed local array, low byte then high byte, after WAIT_STATES
// wait cycles. Addresses with any bit set above the array range complete
// normally but flag err, suppress writes and read back 16'hFFFF.
// Ports:
//   clk    system clock, rising edge
//   reset  asynchronous active-low reset
//   bus    slave side of bus_mem_responder_if (req/RD_WR/Direction/Data_wr in,
//          Data_rd/ready/busy/err out)
module bus_mem_responder #(
    parameter int ADDR_W      = 20,
    parameter int DEPTH_LOG2  = 8,
    parameter int WAIT_STATES = 2
) (
    input  logic                clk,
    input  logic                reset,
    bus_mem_responder_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_LO,
        S_HI,
        S_DONE
    } state_t;

    localparam logic [3:0] WAIT_LAST = 4'(WAIT_STATES - 1);

    state_t                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic                    wr_q, wr_d;
    logic                    oor_q, oor_d;
    logic [DEPTH_LOG2-1:0]   addr_q, addr_d;
    logic [15:0]             wdata_q, wdata_d;
    logic [15:0]             rdata_q, rdata_d;

    logic [7:0]              mem [0:(2**DEPTH_LOG2)-1];
    logic                    mem_we;
    logic [DEPTH_LOG2-1:0]   mem_waddr;
    logic [7:0]              mem_wdata;
    logic [DEPTH_LOG2-1:0]   addr_hi;

    // High byte address wraps naturally within the array width.
    assign addr_hi = addr_q + DEPTH_LOG2'(1);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        wr_d      = wr_q;
        oor_d     = oor_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        mem_we    = 1'b0;
        mem_waddr = addr_q;
        mem_wdata = wdata_q[7:0];
        case (state_q)
            S_IDLE: begin
                if (bus.req) begin
                    wr_d    = bus.RD_WR;
                    addr_d  = bus.Direction[DEPTH_LOG2-1:0];
                    oor_d   = |bus.Direction[ADDR_W-1:DEPTH_LOG2];
                    wdata_d = bus.Data_wr;
                    cnt_d   = '0;
                    state_d = (WAIT_STATES > 0) ? S_WAIT : S_LO;
                end
            end
            S_WAIT: begin
                if (cnt_q == WAIT_LAST) begin
                    state_d = S_LO;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_LO: begin
                if (wr_q) begin
                    mem_we    = !oor_q;
                    mem_waddr = addr_q;
                    mem_wdata = wdata_q[7:0];
                end else begin
                    rdata_d[7:0] = oor_q ? 8'hFF : mem[addr_q];
                end
                state_d = S_HI;
            end
            S_HI: begin
                if (wr_q) begin
                    mem_we    = !oor_q;
                    mem_waddr = addr_hi;
                    mem_wdata = wdata_q[15:8];
                end else begin
                    rdata_d[15:8] = oor_q ? 8'hFF : mem[addr_hi];
                end
                state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            wr_q    <= 1'b0;
            oor_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            oor_q   <= oor_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    // Array is not reset; mem_we is low whenever reset holds the FSM in IDLE.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    assign bus.Data_rd = rdata_q;
    assign bus.ready   = (state_q == S_DONE);
    assign bus.busy    = (state_q != S_IDLE);
    assign bus.err     = (state_q == S_DONE) && oor_q;

endmodule

// File: tb/tb_bus_mem_responder.sv
// Directed testbench for bus_mem_responder (WAIT_STATES = 2, 256-byte array).
module tb_bus_mem_responder;

    logic clk;
    logic reset;

    int checks   = 0;
    int failures = 0;

    logic [15:0] rd_v;
    logic        er_v;
    int          lat_v;
    int          bcnt_v;

    bus_mem_responder_if #(.ADDR_W(20)) bus ();

    bus_mem_responder #(
        .ADDR_W      (20),
        .DEPTH_LOG2  (8),
        .WAIT_STATES (2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One transaction. Inputs are scrambled after acceptance to show they
    // are latched. With hold=1, req stays high through the whole transaction
    // including the ready cycle.
    task automatic txn(input logic rw, input logic [19:0] a, input logic [15:0] d,
                       input bit hold);
        bit seen;
        @(posedge clk); #1;
        bus.req = 1'b1; bus.RD_WR = rw; bus.Direction = a; bus.Data_wr = d;
        @(posedge clk); #1;
        if (!hold) bus.req = 1'b0;
        bus.RD_WR = ~rw; bus.Direction = ~a; bus.Data_wr = ~d;
        lat_v = 0; bcnt_v = 0; seen = 1'b0; rd_v = '0; er_v = 1'b0;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (bus.busy) bcnt_v++;
            if (bus.ready) begin
                lat_v = k; rd_v = bus.Data_rd; er_v = bus.err; seen = 1'b1;
                break;
            end
        end
        if (!seen) check("timeout", 32'(seen), 32'd1);
    endtask

    initial begin
        int extra;
        reset = 1'b0;
        bus.req = 1'b0; bus.RD_WR = 1'b0; bus.Direction = '0; bus.Data_wr = '0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready", 32'(bus.ready), 32'd0);
        check("rst_busy",  32'(bus.busy),  32'd0);
        check("rst_err",   32'(bus.err),   32'd0);
        check("rst_data",  32'(bus.Data_rd), 32'h0000);
        @(posedge clk); #1; reset = 1'b1;

        // Basic write/read with latency and busy span
        txn(1'b1, 20'h00010, 16'hBEEF, 1'b0);
        check("wr_lat",  32'(lat_v),  32'd5);
        check("wr_busy", 32'(bcnt_v), 32'd5);
        check("wr_err",  32'(er_v),   32'd0);
        check("wr_data_kept", 32'(rd_v), 32'h0000);
        txn(1'b0, 20'h00010, 16'h0000, 1'b0);
        check("rd_lat",  32'(lat_v),  32'd5);
        check("rd_busy", 32'(bcnt_v), 32'd5);
        check("rd_data", 32'(rd_v),   32'hBEEF);
        check("rd_err",  32'(er_v),   32'd0);

        // Address wrap at top of array
        txn(1'b1, 20'h000FF, 16'h1234, 1'b0);
        txn(1'b0, 20'h00000, 16'h0000, 1'b0);
        check("wrap_lo", 32'(rd_v[7:0]), 32'h12);
        txn(1'b0, 20'h000FF, 16'h0000, 1'b0);
        check("wrap_rd", 32'(rd_v), 32'h1234);

        // Out of range
        txn(1'b1, 20'h10010, 16'hAAAA, 1'b0);
        check("oor_wr_err", 32'(er_v), 32'd1);
        check("oor_wr_lat", 32'(lat_v), 32'd5);
        txn(1'b0, 20'h00010, 16'h0000, 1'b0);
        check("oor_no_wr", 32'(rd_v), 32'hBEEF);
        check("oor_clr_err", 32'(er_v), 32'd0);
        txn(1'b0, 20'h10010, 16'h0000, 1'b0);
        check("oor_rd_data", 32'(rd_v), 32'hFFFF);
        check("oor_rd_err",  32'(er_v), 32'd1);
        @(negedge clk);
        check("err_after_done", 32'(bus.err), 32'd0);

        // req held high through a transaction, including the ready cycle
        txn(1'b0, 20'h000FF, 16'h0000, 1'b1);
        check("hold_lat",  32'(lat_v), 32'd5);
        check("hold_data", 32'(rd_v),  32'h1234);
        @(posedge clk); #1; bus.req = 1'b0;
        @(negedge clk);
        check("hold_idle_after_done", 32'(bus.busy), 32'd0);
        extra = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (bus.ready || bus.busy) extra++;
        end
        check("hold_no_extra", 32'(extra), 32'd0);

        // Reset asserted in HI during a write
        txn(1'b1, 20'h00020, 16'h1111, 1'b0);
        @(posedge clk); #1;
        bus.req = 1'b1; bus.RD_WR = 1'b1; bus.Direction = 20'h00020; bus.Data_wr = 16'h5678;
        @(posedge clk); #1; bus.req = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b0;
        #1;
        check("mid_rst_busy",  32'(bus.busy),    32'd0);
        check("mid_rst_ready", 32'(bus.ready),   32'd0);
        check("mid_rst_data",  32'(bus.Data_rd), 32'h0000);
        @(posedge clk); #1; reset = 1'b1;
        txn(1'b0, 20'h00020, 16'h0000, 1'b0);
        check("mid_rst_lo", 32'(rd_v[7:0]),  32'h78);
        check("mid_rst_hi", 32'(rd_v[15:8]), 32'h11);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
